stage1_fetch: RTL
=================

Name: stage1_fetch

Overview:
Instruction-fetch stage of the 16-bit multicycle datapath, directly upstream of stage 2 (memory/MDR stage).
- Owns PC, old-PC and IR.
- Issues instruction reads through the shared synchronous memory port; read data returns one cycle after the address.
- Presents one instruction at a time to the decode/execute side with a valid/ack handshake.
- Accepts PC redirects (branch/jump) from downstream.

Parameters:
WIDTH, 16, datapath/address width
RESET_PC, 16'h0000, PC value loaded on reset
PC_INC, 2, PC increment per fetched instruction (address units)

Ports:
CLK  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
mem_addr  output  WIDTH  instruction address driven to the memory port
mem_re  output  1  instruction read request (memory read data valid on the following cycle)
mem_data  input  WIDTH  memory read data (instruction word)
instr_valid  output  1  ir_out/oldpc_out hold a fetched instruction
instr_ack  input  1  downstream consumed the instruction (sampled only while instr_valid=1)
ir_out  output  WIDTH  instruction register
oldpc_out  output  WIDTH  address of the instruction in ir_out
pc_out  output  WIDTH  current PC (next fetch address)
redirect_valid  input  1  load redirect_pc into PC and restart fetch
redirect_pc  input  WIDTH  redirect target
fetch_count  output  WIDTH  count of instructions latched into IR; wraps

Behaviour:
- Reset is asynchronous and active-high, and takes effect immediately, including mid-fetch.
  - PC=RESET_PC; IR, oldpc and fetch_count = 0.
  - instr_valid=0, mem_re=0, mem_addr=RESET_PC, state=ISSUE.
- FSM states: ISSUE, LATCH, HOLD.
- ISSUE:
  - Combinational outputs: mem_addr=PC, mem_re=1, instr_valid=0.
  - Next state: LATCH.
- LATCH:
  - mem_data is valid this cycle. mem_re=0; mem_addr continues to show PC.
  - On the edge: IR<=mem_data, oldpc<=PC, PC<=PC+PC_INC (mod 2^WIDTH), fetch_count<=fetch_count+1 (wraps).
  - Next state: HOLD.
- HOLD:
  - instr_valid=1. IR, oldpc and PC are stable.
  - instr_ack=1 -> ISSUE.
  - Otherwise stay in HOLD indefinitely (stall).
- Fetch latency: instr_valid rises 2 cycles after entering ISSUE. Minimum throughput is 1 instruction per 3 cycles (ack in the first HOLD cycle).
- redirect_valid, in any state, has priority over all other transitions:
  - PC<=redirect_pc; next state ISSUE; instr_valid drops on the next cycle.
  - In LATCH, the fetched word is discarded: IR, oldpc and fetch_count are unchanged.
  - In HOLD with instr_ack=1 at the same time: the ack is honoured (instruction consumed) and the redirect PC is used. No extra instruction is delivered.
  - In ISSUE: the in-flight read is abandoned and ISSUE re-issues from redirect_pc on the following cycle.
- Wrap-around: PC at 16'hFFFE with PC_INC=2 becomes 16'h0000; no flag.
- instr_ack while instr_valid=0 is ignored.
- pc_out is always the registered PC; ir_out and oldpc_out are always registered values.

Decomposition:
- Shared datapath package:
  - WIDTH
  - RESET_PC
  - FSM state encoding (ISSUE=2'd0, LATCH=2'd1, HOLD=2'd2)
  - memory-mapped I/O address constants 16'h3FFC/16'h3FFE, for stage 2 and later stages
- No sub-module required. The PC register with load/increment and async reset may be split out as pc_reg if reused by stage 3.

Test Plan:
- Reset release: memory model returns word[0]=16'h1234. After reset drops: mem_re=1 and mem_addr=0000 in cycle 0; instr_valid=1 in cycle 2 with ir_out=1234, oldpc_out=0000, pc_out=0002, fetch_count=1.
- Sequential fetch: ack in the first HOLD cycle, memory word[2]=16'h1337. Second instruction has ir_out=1337, oldpc_out=0002, pc_out=0004, with 3 cycles between instr_valid rises.
- Stall: instr_ack held low for 10 cycles. instr_valid, ir_out and pc_out are constant; mem_re=0 throughout.
- Redirect in LATCH: redirect_pc=16'h3FFC, memory word[3FFC]=16'hDEAD. The first word is discarded and fetch_count is unchanged. Next instr_valid shows ir_out=DEAD, oldpc_out=3FFC, pc_out=3FFE.
- Simultaneous ack + redirect in HOLD: redirect_pc=16'h0010. Exactly one new fetch occurs, from 0010; no fetch from the old PC.
- Wrap and async reset: redirect to FFFE, then fetch gives pc_out=0000. Asserting reset mid-LATCH immediately clears instr_valid and sets pc_out=0000 without waiting for a clock edge.

Source files
------------

// File: rtl/stage1_fetch_pkg.sv
// rtl/stage1_fetch_pkg.sv - shared datapath constants and fetch FSM encoding
package stage1_fetch_pkg;

   localparam int                DATA_W       = 16;
   localparam logic [DATA_W-1:0] RESET_PC_DEF = 16'h0000;
   localparam int                PC_INC_DEF   = 2;

   // Memory-mapped I/O words, decoded by stage 2 and later stages
   localparam logic [DATA_W-1:0] IO_ADDR_IN   = 16'h3FFC;
   localparam logic [DATA_W-1:0] IO_ADDR_OUT  = 16'h3FFE;

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_LATCH = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/stage1_fetch_if.sv
// rtl/stage1_fetch_if.sv - memory port, instruction handshake and redirect bundle of the fetch stage
interface stage1_fetch_if #(
   parameter int WIDTH = stage1_fetch_pkg::DATA_W
);

   logic [WIDTH-1:0] mem_addr;
   logic             mem_re;
   logic [WIDTH-1:0] mem_data;
   logic             instr_valid;
   logic             instr_ack;
   logic [WIDTH-1:0] ir_out;
   logic [WIDTH-1:0] oldpc_out;
   logic [WIDTH-1:0] pc_out;
   logic             redirect_valid;
   logic [WIDTH-1:0] redirect_pc;
   logic [WIDTH-1:0] fetch_count;

   modport master (
      output mem_addr, mem_re, instr_valid, ir_out, oldpc_out, pc_out, fetch_count,
      input  mem_data, instr_ack, redirect_valid, redirect_pc
   );

   modport slave (
      input  mem_addr, mem_re, instr_valid, ir_out, oldpc_out, pc_out, fetch_count,
      output mem_data, instr_ack, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/stage1_fetch_pc_reg.sv
// rtl/stage1_fetch_pc_reg.sv - program counter with load/increment and asynchronous reset
module stage1_fetch_pc_reg
   import stage1_fetch_pkg::*;
#(
   parameter int               WIDTH    = DATA_W,
   parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEF,
   parameter int               PC_INC   = PC_INC_DEF
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] pc_o
);

   localparam logic [WIDTH-1:0] INC = WIDTH'(PC_INC);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;

   // Load wins over increment; the increment wraps silently at the top of the address space
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_val_i;
      end else if (inc_i) begin
         pc_d = pc_q + INC;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/stage1_fetch.sv
// rtl/stage1_fetch.sv - instruction fetch stage: PC/old-PC/IR, memory read issue, valid/ack delivery, redirects
module stage1_fetch
   import stage1_fetch_pkg::*;
#(
   parameter int               WIDTH    = DATA_W,
   parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEF,
   parameter int               PC_INC   = PC_INC_DEF
) (
   input  logic           CLK,
   input  logic           reset,
   stage1_fetch_if.master bus
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   fetch_state_e     state_q, state_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic [WIDTH-1:0] oldpc_q, oldpc_d;
   logic [WIDTH-1:0] fcnt_q, fcnt_d;
   logic [WIDTH-1:0] pc_q;
   logic             pc_inc;

   stage1_fetch_pc_reg #(
      .WIDTH    (WIDTH),
      .RESET_PC (RESET_PC),
      .PC_INC   (PC_INC)
   ) u_pc_reg (
      .CLK        (CLK),
      .reset      (reset),
      .load_i     (bus.redirect_valid),
      .load_val_i (bus.redirect_pc),
      .inc_i      (pc_inc),
      .pc_o       (pc_q)
   );

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      oldpc_d = oldpc_q;
      fcnt_d  = fcnt_q;
      pc_inc  = 1'b0;
      case (state_q)
         ST_ISSUE: state_d = ST_LATCH;
         ST_LATCH: begin
            state_d = ST_HOLD;
            ir_d    = bus.mem_data;
            oldpc_d = pc_q;
            fcnt_d  = fcnt_q + ONE;
            pc_inc  = 1'b1;
         end
         ST_HOLD: begin
            if (bus.instr_ack) begin
               state_d = ST_ISSUE;
            end
         end
         default: state_d = ST_ISSUE;
      endcase
      // A redirect drops any word being latched and restarts fetch from the new PC
      if (bus.redirect_valid) begin
         state_d = ST_ISSUE;
         ir_d    = ir_q;
         oldpc_d = oldpc_q;
         fcnt_d  = fcnt_q;
         pc_inc  = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= ST_ISSUE;
         ir_q    <= '0;
         oldpc_q <= '0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         oldpc_q <= oldpc_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // Read request is masked while reset is held so no fetch leaks out of the ISSUE reset state
   assign bus.mem_addr    = pc_q;
   assign bus.mem_re      = (state_q == ST_ISSUE) && !reset;
   assign bus.instr_valid = (state_q == ST_HOLD);
   assign bus.ir_out      = ir_q;
   assign bus.oldpc_out   = oldpc_q;
   assign bus.pc_out      = pc_q;
   assign bus.fetch_count = fcnt_q;

endmodule
